// File: rtl/timeslice_arbiter.sv
// Round-robin arbiter granting one shared resource per time slice.
// A grant ends on release or, when others are waiting, on slice expiry.
module timeslice_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SLICE_WIDTH = 4,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     io_requests,
  input  logic [SLICE_WIDTH-1:0] io_sliceLength,
  output logic [NUM_REQ-1:0]     io_grant,
  output logic                   io_grantValid,
  output logic [IDW-1:0]         io_grantId,
  output logic                   io_preempt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                   state_q;
  logic [NUM_REQ-1:0]       grant_q;
  logic [IDW-1:0]           grant_id_q;
  logic                     preempt_q;
  logic [SLICE_WIDTH-1:0]   slice_q;
  logic [SLICE_WIDTH-1:0]   cnt_q;
  logic [IDW-1:0]           ptr_q;

  logic [IDW-1:0]           pick_id;
  logic                     pick_found;
  logic [NUM_REQ-1:0]       other_req;
  logic [SLICE_WIDTH-1:0]   cnt_max;
  logic [IDW-1:0]           ptr_after_owner;
  logic                     slice_expired;

  // First requester at or above the round-robin pointer, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!pick_found && io_requests[idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_other
      assign other_req[gi] = io_requests[gi] && (grant_id_q != IDW'(gi));
    end
  endgenerate

  // Unlimited slices let the counter run up to all-ones and sit there.
  assign cnt_max         = (slice_q == '0) ? '1 : (slice_q - SLICE_WIDTH'(1));
  assign slice_expired   = (slice_q != '0) && (cnt_q == cnt_max);
  assign ptr_after_owner = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : (grant_id_q + IDW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      preempt_q  <= 1'b0;
      slice_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q    <= NUM_REQ'(1) << pick_id;
            grant_id_q <= pick_id;
            slice_q    <= io_sliceLength;
            cnt_q      <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (!io_requests[grant_id_q]) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= ptr_after_owner;
            state_q    <= IDLE;
          end else if (slice_expired && (|other_req)) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            preempt_q  <= 1'b1;
            ptr_q      <= ptr_after_owner;
            state_q    <= IDLE;
          end else if (cnt_q != cnt_max) begin
            cnt_q <= cnt_q + SLICE_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_grant      = grant_q;
  assign io_grantValid = |grant_q;
  assign io_grantId    = grant_id_q;
  assign io_preempt    = preempt_q;

endmodule

// File: tb/tb_timeslice_arbiter.sv
// Directed and random bench for timeslice_arbiter, checked every cycle
// against an owner/held-cycles model of the arbitration rules.
module tb_timeslice_arbiter;
  localparam int N  = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [SW-1:0] slice;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          preempt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: who owns the resource and for how many cycles so far.
  int owner   = -1;
  int held    = 0;
  int lslice  = 0;
  int ptr     = 0;
  bit pre     = 1'b0;
  int order_q[$];
  logic prev_valid = 1'b0;

  timeslice_arbiter #(.NUM_REQ(N), .SLICE_WIDTH(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_requests   (req),
    .io_sliceLength(slice),
    .io_grant      (grant),
    .io_grantValid (grant_valid),
    .io_grantId    (grant_id),
    .io_preempt    (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    int others;
    if (reset) begin
      owner = -1; ptr = 0; pre = 1'b0; held = 0;
    end else if (owner < 0) begin
      pre = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && req[(ptr + k) % N]) owner = (ptr + k) % N;
      end
      if (owner >= 0) begin
        held   = 1;
        lslice = int'(slice);
      end
    end else begin
      pre    = 1'b0;
      others = int'(req) & ~(1 << owner);
      if (!req[owner]) begin
        ptr = (owner + 1) % N; owner = -1;
      end else if (lslice != 0 && held >= lslice && others != 0) begin
        pre = 1'b1; ptr = (owner + 1) % N; owner = -1;
      end else begin
        held++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("grant",   32'(grant),       (owner >= 0) ? (32'd1 << owner) : 32'd0);
    chk("valid",   32'(grant_valid), (owner >= 0) ? 32'd1 : 32'd0);
    chk("grantId", 32'(grant_id),    (owner >= 0) ? 32'(owner) : 32'd0);
    chk("preempt", 32'(preempt),     32'(pre));
    if (grant_valid && !prev_valid) order_q.push_back(int'(grant_id));
    prev_valid = grant_valid;
    $display("cyc=%0d rst=%0b req=%b slice=%0d grant=%b id=%0d pre=%0b",
             cyc, reset, req, slice, grant, grant_id, preempt);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b0;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = 4'b1111; slice = 4'd3;

    // Reset held two cycles with every request high.
    do_reset(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_preempt", 32'(preempt), 32'd0);
    cycle();
    chk("first_grant", 32'(grant), 32'b0001);

    // Round-robin with slice 3: order 0,1,2,3,0.
    order_q.delete();
    order_q.push_back(0);
    for (int i = 0; i < 16; i++) cycle();
    chk("rr_count", 32'(order_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < order_q.size()) chk("rr_order", 32'(order_q[i]), 32'(exp_order[i]));

    // Single requester keeps its grant past the slice.
    do_reset(1);
    req = 4'b0100; slice = 4'd3;
    for (int i = 0; i < 11; i++) cycle();
    chk("single_grant", 32'(grant), 32'b0100);
    chk("single_id", 32'(grant_id), 32'd2);

    // Owner 1 releases after two granted cycles; requester 2 wins over 0.
    do_reset(1);
    req = 4'b0110; slice = 4'd5;
    cycle(); cycle();
    chk("rel_owner", 32'(grant), 32'b0010);
    req = 4'b0101;
    cycle();
    chk("rel_drop", 32'(grant), 32'd0);
    chk("rel_nopre", 32'(preempt), 32'd0);
    cycle();
    chk("rel_next", 32'(grant), 32'b0100);

    // Unlimited slice: requester 0 holds for 40 cycles.
    do_reset(1);
    req = 4'b0011; slice = 4'd0;
    for (int i = 0; i < 40; i++) cycle();
    chk("unl_grant", 32'(grant), 32'b0001);

    // Slice change mid-grant only affects the next grant.
    do_reset(1);
    req = 4'b0011; slice = 4'd3;
    cycle();
    slice = 4'd7;
    cycle(); cycle(); cycle();
    chk("chg_pre", 32'(preempt), 32'd1);
    for (int i = 0; i < 7; i++) cycle();
    chk("chg_long", 32'(grant), 32'b0010);
    cycle();
    chk("chg_long_end", 32'(preempt), 32'd1);

    // Reset in the middle of a grant.
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_pre", 32'(preempt), 32'd0);
    reset = 1'b0;
    cycle();
    chk("mid_rst_ptr", 32'(grant), 32'b0001);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 7) == 0) slice = SW'($urandom_range(0, 5));
      reset = ($urandom_range(0, 60) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
